// File: rtl/cpu_trace_capture.sv
// Execution-trace ring buffer for the single-cycle LEGv8 CPU: records PC/instr/ALU/ctrl each cycle,
// freezes after a PC-match trigger plus post-trigger window, then drains oldest-first over valid/ready.
module cpu_trace_capture #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [ADDR_W-1:0]          trig_pc,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic [31:0]                instr_in,
    input  logic [DATA_W-1:0]          alu_in,
    input  logic [7:0]                 ctrl_in,
    output logic [1:0]                 state_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [ADDR_W-1:0]          rd_pc,
    output logic [31:0]                rd_instr,
    output logic [DATA_W-1:0]          rd_alu,
    output logic [7:0]                 rd_ctrl
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ADDR_W + 32 + DATA_W + 8;

    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, post_cnt_q, post_cnt_d;
    logic            wr_en, done;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   rd_ent;

    assign rd_valid = (state_q == DONE) && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = PRE;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end
            end
            PRE, POST: begin
                if (arm) begin
                    state_d  = PRE;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
                    if (state_q == PRE) begin
                        if (trig_en && (pc_in == trig_pc)) begin
                            post_cnt_d = CW'(1);
                            if (POST_TRIG == 1) done = 1'b1;
                            else state_d = POST;
                        end
                    end else begin
                        post_cnt_d = post_cnt_q + CW'(1);
                        if (post_cnt_d == CW'(POST_TRIG)) done = 1'b1;
                    end
                    // Oldest entry sits count positions behind the post-write pointer.
                    if (done) begin
                        state_d  = DONE;
                        rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                    end
                end
            end
            DONE: begin
                if (rd_valid && rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                    if (count_q == CW'(1)) state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {pc_in, instr_in, alu_in, ctrl_in};
    end

    assign rd_ent    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign rd_pc     = rd_ent[EW-1 -: ADDR_W];
    assign rd_instr  = rd_ent[DATA_W+8 +: 32];
    assign rd_alu    = rd_ent[8 +: DATA_W];
    assign rd_ctrl   = rd_ent[7:0];
    assign state_out = state_q;
    assign count_out = count_q;
endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: directed PC streams, expected entries queued up front,
// negedge monitors pop and compare every accepted read beat.
module tb_cpu_trace_capture;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] alu;
        logic [7:0]  ctrl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0, arm1 = 1'b0;
    logic        trig_en = 1'b0, trig_en1 = 1'b0;
    logic [63:0] trig_pc = '0;
    logic [63:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic [63:0] alu_in = '0;
    logic [7:0]  ctrl_in = '0;
    logic        rd_ready = 1'b1;
    logic        stall_mode = 1'b0;

    logic [1:0]  state0, state1;
    logic [4:0]  count0;
    logic [2:0]  count1;
    logic        vld0, vld1;
    logic [63:0] pc0, pc1, alu0, alu1;
    logic [31:0] ins0, ins1;
    logic [7:0]  ctl0, ctl1;

    int n_checks = 0;
    int n_fail   = 0;
    ent_t q0[$];
    ent_t q1[$];
    logic [63:0] last_pc1 = '0;

    always #5 clk = ~clk;

    cpu_trace_capture #(.ADDR_W(64), .DATA_W(64), .DEPTH(16), .POST_TRIG(8)) dut0 (
        .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in), .ctrl_in(ctrl_in),
        .state_out(state0), .count_out(count0), .rd_valid(vld0), .rd_ready(rd_ready),
        .rd_pc(pc0), .rd_instr(ins0), .rd_alu(alu0), .rd_ctrl(ctl0));

    cpu_trace_capture #(.ADDR_W(64), .DATA_W(64), .DEPTH(4), .POST_TRIG(1)) dut1 (
        .clk(clk), .rst(rst), .arm(arm1), .trig_en(trig_en1), .trig_pc(trig_pc),
        .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in), .ctrl_in(ctrl_in),
        .state_out(state1), .count_out(count1), .rd_valid(vld1), .rd_ready(rd_ready),
        .rd_pc(pc1), .rd_instr(ins1), .rd_alu(alu1), .rd_ctrl(ctl1));

    function automatic ent_t mk(input logic [63:0] pc);
        ent_t e;
        e.pc    = pc;
        e.instr = {pc[15:0] ^ 16'hBEEF, pc[15:0]};
        e.alu   = ~pc + 64'h1234;
        e.ctrl  = pc[9:2];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic [63:0] pc, input logic a0, input logic a1);
        ent_t e;
        e = mk(pc);
        pc_in = e.pc; instr_in = e.instr; alu_in = e.alu; ctrl_in = e.ctrl;
        arm = a0; arm1 = a1;
        @(posedge clk); #1;
        arm = 1'b0; arm1 = 1'b0;
    endtask

    task automatic push0(input logic [63:0] lo, input logic [63:0] hi);
        for (logic [63:0] p = lo; p <= hi; p += 64'd4) q0.push_back(mk(p));
    endtask

    task automatic wait_idle(input string name, input bit which, input int budget);
        int n = 0;
        while (((which ? state1 : state0) != 2'd0) && n < budget) begin
            cyc(64'h0, 1'b0, 1'b0);
            n++;
        end
        chk({name, "_idle"}, 64'(which ? state1 : state0), 64'd0);
        chk({name, "_drained"}, 64'(which ? q1.size() : q0.size()), 64'd0);
    endtask

    // Stall-pattern driver: 1,0,0 repeating when stall_mode is set.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            rd_ready = stall_mode ? (ph == 0) : 1'b1;
            ph = (ph + 1) % 3;
        end
    end

    // dut0 monitor: pop on handshake, verify outputs frozen while stalled.
    initial begin
        ent_t held, got;
        bit   stalled = 1'b0;
        forever begin
            @(negedge clk);
            got = {pc0, ins0, alu0, ctl0};
            if (!rst && stalled) begin
                chk("stall_valid", 64'(vld0), 64'd1);
                chk("stall_pc", got.pc, held.pc);
                chk("stall_alu", got.alu, held.alu);
            end
            stalled = !rst && vld0 && !rd_ready;
            held = got;
            if (!rst && vld0 && rd_ready) begin
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd0_unexpected: got pc 0x%0h expected no entry", got.pc);
                end else begin
                    ent_t e;
                    e = q0.pop_front();
                    chk("rd0_pc", got.pc, e.pc);
                    chk("rd0_instr", 64'(got.instr), 64'(e.instr));
                    chk("rd0_alu", got.alu, e.alu);
                    chk("rd0_ctrl", 64'(got.ctrl), 64'(e.ctrl));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && vld1 && rd_ready) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd1_unexpected: got pc 0x%0h expected no entry", pc1);
                end else begin
                    ent_t e;
                    e = q1.pop_front();
                    chk("rd1_pc", pc1, e.pc);
                    chk("rd1_alu", alu1, e.alu);
                    last_pc1 = pc1;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(state0), 64'd0);
        chk("rst_count", 64'(count0), 64'd0);
        chk("rst_valid", 64'(vld0), 64'd0);
        chk("rst_rdpc", pc0, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: trigger after wrap, full buffer, trigger entry 9th
        trig_en = 1'b1; trig_pc = 64'h40;
        push0(64'h20, 64'h5C);
        for (int k = 0; k <= 23; k++) cyc(64'(4 * k), k == 0, 1'b0);
        chk("t1_done", 64'(state0), 64'd3);
        chk("t1_count", 64'(count0), 64'd16);
        wait_idle("t1", 1'b0, 40);

        // 2: trigger before buffer fills
        trig_pc = 64'h10;
        push0(64'h04, 64'h2C);
        for (int k = 0; k <= 10; k++) cyc(64'(4 * k), k == 0, 1'b0);
        chk("t2_post", 64'(state0), 64'd2);
        cyc(64'h2C, 1'b0, 1'b0);
        chk("t2_done", 64'(state0), 64'd3);
        chk("t2_count", 64'(count0), 64'd11);
        wait_idle("t2", 1'b0, 40);

        // 3: stalled readout
        trig_pc = 64'h40;
        stall_mode = 1'b1;
        push0(64'h20, 64'h5C);
        for (int k = 0; k <= 23; k++) cyc(64'(4 * k), k == 0, 1'b0);
        chk("t3_done", 64'(state0), 64'd3);
        wait_idle("t3", 1'b0, 200);
        stall_mode = 1'b0;

        // 4: async reset in POST, then re-arm
        for (int k = 0; k <= 18; k++) cyc(64'(4 * k), k == 0, 1'b0);
        chk("t4_post", 64'(state0), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("t4_state", 64'(state0), 64'd0);
        chk("t4_valid", 64'(vld0), 64'd0);
        chk("t4_count", 64'(count0), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        push0(64'h20, 64'h5C);
        for (int k = 0; k <= 23; k++) cyc(64'(4 * k), k == 0, 1'b0);
        chk("t4_redone", 64'(state0), 64'd3);
        wait_idle("t4", 1'b0, 40);

        // 5: re-arm in POST, trigger PC never recurs
        for (int k = 0; k <= 18; k++) cyc(64'(4 * k), k == 0 || k == 18, 1'b0);
        chk("t5_state", 64'(state0), 64'd1);
        chk("t5_count", 64'(count0), 64'd0);
        for (int k = 19; k <= 40; k++) cyc(64'(4 * k), 1'b0, 1'b0);
        chk("t5_stay", 64'(state0), 64'd1);
        chk("t5_sat", 64'(count0), 64'd16);
        chk("t5_valid", 64'(vld0), 64'd0);
        rst = 1'b1; #2 rst = 1'b0;
        @(posedge clk); #1;

        // 6: POST_TRIG=1 on a depth-4 instance
        trig_pc = 64'h0C; trig_en1 = 1'b1;
        q1.push_back(mk(64'h04)); q1.push_back(mk(64'h08)); q1.push_back(mk(64'h0C));
        for (int k = 0; k <= 3; k++) cyc(64'(4 * k), 1'b0, k == 0);
        chk("t6_done", 64'(state1), 64'd3);
        chk("t6_count", 64'(count1), 64'd3);
        wait_idle("t6", 1'b1, 20);
        chk("t6_last", last_pc1, 64'h0C);
        trig_en1 = 1'b0;
        for (int k = 0; k <= 10; k++) cyc(64'(4 * k), 1'b0, k == 0);
        chk("t6_noen_state", 64'(state1), 64'd1);
        chk("t6_noen_count", 64'(count1), 64'd4);
        chk("t0_untouched", 64'(state0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
